// File: rtl/merak_chan_pkg.sv
// rtl/merak_chan_pkg.sv - shared state encodings, limits and clog2 helper for the Merak channel arbiter
package merak_chan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  localparam int MERAK_MAX_N = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// rtl/priority_encoder_n.sv - combinational N-input priority encoder, lowest set index wins
module priority_encoder_n
  import merak_chan_pkg::*;
#(
  parameter int N = 16,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  Din,
  output logic [IW-1:0] Dout,
  output logic          Valid
);

  // Scan downward so the lowest set bit is the last (winning) assignment.
  always_comb begin
    Dout = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (Din[i]) Dout = IW'(i);
    end
    Valid = |Din;
  end

endmodule

// File: rtl/merak_rr_arbiter.sv
// rtl/merak_rr_arbiter.sv - round-robin N-channel arbiter, grant held until the owner releases it
// Optional watchdog forced release is built when MERAK_ARB_TIMEOUT_EN is defined.
module merak_rr_arbiter
  import merak_chan_pkg::*;
#(
  parameter int N = 16
`ifdef MERAK_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 256
`endif
  , localparam int IW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [N-1:0]  Grant,
  output logic [IW-1:0] Dout,
  output logic          Valid
`ifdef MERAK_ARB_TIMEOUT_EN
  ,
  output logic          timeout
`endif
);

  arb_state_t    state, state_nx;
  logic [IW-1:0] ptr, ptr_nx;
  logic [N-1:0]  grant_nx;
  logic [IW-1:0] dout_nx;
  logic          valid_nx;

  logic [N-1:0]  cand, mask, masked;
  logic [IW-1:0] m_idx, f_idx, win_idx;
  logic          m_vld, f_vld;
  logic          owner_req, force_rel, release_evt, load;

  // The owner's own request is excluded while holding so it cannot be re-granted back-to-back.
  always_comb begin
    cand = (state == ST_HOLD) ? (req & ~Grant) : req;
    for (int i = 0; i < N; i++) mask[i] = (i >= int'(ptr));
    masked = cand & mask;
  end

  priority_encoder_n #(.N(N)) u_masked (
    .Din   (masked),
    .Dout  (m_idx),
    .Valid (m_vld)
  );

  priority_encoder_n #(.N(N)) u_full (
    .Din   (cand),
    .Dout  (f_idx),
    .Valid (f_vld)
  );

  assign win_idx   = m_vld ? m_idx : f_idx;
  assign owner_req = |(req & Grant);

`ifdef MERAK_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT);
  logic [CW-1:0] cnt, cnt_nx;

  // Forced release only when nothing else is already releasing the owner.
  assign force_rel = (state == ST_HOLD) && !done && owner_req && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_nx = cnt;
    if (load) cnt_nx = '0;
    else if (state == ST_HOLD) cnt_nx = cnt + 1'b1;
  end
`else
  assign force_rel = 1'b0;
`endif

  assign release_evt = (state == ST_HOLD) && (done || !owner_req || force_rel);

  always_comb begin
    state_nx = state;
    grant_nx = Grant;
    dout_nx  = Dout;
    valid_nx = Valid;
    ptr_nx   = ptr;
    load     = 1'b0;
    if (state == ST_IDLE) begin
      load = f_vld;
    end else if (release_evt) begin
      if (f_vld) begin
        load = 1'b1;
      end else begin
        state_nx = ST_IDLE;
        grant_nx = '0;
        valid_nx = 1'b0;
      end
    end
    if (load) begin
      state_nx = ST_HOLD;
      grant_nx = N'(1) << win_idx;
      dout_nx  = win_idx;
      valid_nx = 1'b1;
      ptr_nx   = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      Grant   <= '0;
      Dout    <= '0;
      Valid   <= 1'b0;
      ptr     <= '0;
`ifdef MERAK_ARB_TIMEOUT_EN
      cnt     <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      Grant   <= grant_nx;
      Dout    <= dout_nx;
      Valid   <= valid_nx;
      ptr     <= ptr_nx;
`ifdef MERAK_ARB_TIMEOUT_EN
      cnt     <= cnt_nx;
      timeout <= force_rel;
`endif
    end
  end

endmodule

// File: tb/tb_merak_rr_arbiter.sv
// tb/tb_merak_rr_arbiter.sv - scoreboard bench for merak_rr_arbiter (N=4, TIMEOUT=8 with MERAK_ARB_TIMEOUT_EN)
module tb_merak_rr_arbiter;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] Grant;
  logic [1:0] Dout;
  logic       Valid;
  logic       tmo;

  merak_rr_arbiter #(
    .N(N)
`ifdef MERAK_ARB_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .done  (done),
    .Grant (Grant),
    .Dout  (Dout),
    .Valid (Valid)
`ifdef MERAK_ARB_TIMEOUT_EN
    , .timeout (tmo)
`endif
  );

`ifndef MERAK_ARB_TIMEOUT_EN
  assign tmo = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [3:0] grant;
    logic [1:0] dout;
    logic       valid;
    logic       to;
    int         at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic [3:0] prev_grant;
  logic       prev_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic expect_evt(input string nm, input logic [3:0] g, input logic [1:0] d,
                            input logic v, input logic t, input int lat);
    exp_t e;
    e.name = nm; e.grant = g; e.dout = d; e.valid = v; e.to = t;
    e.at = (lat > 0) ? cyc + lat : 0;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every change of Grant/Valid is an output event checked against the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (Grant !== prev_grant || Valid !== prev_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got grant %b valid %b expected no event", Grant, Valid);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_grant"}, 32'(Grant), 32'(e.grant));
          chk({e.name, "_valid"}, 32'(Valid), 32'(e.valid));
          chk({e.name, "_dout"},  32'(Dout),  32'(e.dout));
          chk({e.name, "_timeout"}, 32'(tmo), 32'(e.to));
          if (e.at != 0) chk({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
        end
      end else if (tmo === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL stray_timeout: got timeout 1 expected 0 without a grant change");
      end
      prev_grant = Grant;
      prev_valid = Valid;
    end
  end

  initial begin
    rst  = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_grant", 32'(Grant), 32'h0);
    chk("reset_valid", 32'(Valid), 32'h0);
    chk("reset_dout",  32'(Dout),  32'h0);
    chk("reset_timeout", 32'(tmo), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    prev_grant = Grant;
    prev_valid = Valid;
    mon_en = 1'b1;

    // req 1010: grant 1, then done hands over to 3, then release to idle
    req = 4'b1010;
    expect_evt("s1_first", 4'b0010, 2'd1, 1'b1, 1'b0, 1);
    tick(1);
    done = 1'b1;
    expect_evt("s1_done", 4'b1000, 2'd3, 1'b1, 1'b0, 1);
    tick(1);
    done = 1'b0;
    req = 4'b0000;
    expect_evt("s1_idle", 4'b0000, 2'd3, 1'b0, 1'b0, 1);
    tick(2);

    // req 1111 with done every cycle: 0,1,2,3,0
    req = 4'b1111;
    expect_evt("s2_g0", 4'b0001, 2'd0, 1'b1, 1'b0, 1);
    tick(1);
    done = 1'b1;
    expect_evt("s2_g1", 4'b0010, 2'd1, 1'b1, 1'b0, 1);
    expect_evt("s2_g2", 4'b0100, 2'd2, 1'b1, 1'b0, 2);
    expect_evt("s2_g3", 4'b1000, 2'd3, 1'b1, 1'b0, 3);
    expect_evt("s2_g0b", 4'b0001, 2'd0, 1'b1, 1'b0, 4);
    tick(4);
    done = 1'b0;
    req = 4'b0000;
    expect_evt("s2_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1);
    tick(2);

    // owner 2 drops its request without done
    req = 4'b0100;
    expect_evt("s3_g2", 4'b0100, 2'd2, 1'b1, 1'b0, 1);
    tick(1);
    req = 4'b0000;
    expect_evt("s3_implicit", 4'b0000, 2'd2, 1'b0, 1'b0, 1);
    tick(2);

    // owner 1 done while still requesting: channel 0 wins, not 1
    req = 4'b0010;
    expect_evt("s4_g1", 4'b0010, 2'd1, 1'b1, 1'b0, 1);
    tick(1);
    req = 4'b0011;
    done = 1'b1;
    expect_evt("s4_no_regrant", 4'b0001, 2'd0, 1'b1, 1'b0, 1);
    tick(1);
    done = 1'b0;
    tick(2);
    req = 4'b0000;
    expect_evt("s4_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1);
    tick(2);

    // done together with implicit release is a single handoff
    req = 4'b1001;
    expect_evt("s4_g3", 4'b1000, 2'd3, 1'b1, 1'b0, 1);
    tick(1);
    req = 4'b0001;
    done = 1'b1;
    expect_evt("s4_single_rel", 4'b0001, 2'd0, 1'b1, 1'b0, 1);
    tick(1);
    done = 1'b0;
    tick(2);
    req = 4'b0000;
    expect_evt("s4_idle2", 4'b0000, 2'd0, 1'b0, 1'b0, 1);
    tick(2);

    // asynchronous reset mid-hold, then lowest requester wins
    req = 4'b0100;
    expect_evt("s5_g2", 4'b0100, 2'd2, 1'b1, 1'b0, 1);
    tick(1);
    #1 rst = 1'b1;
    #1;
    chk("s5_async_grant", 32'(Grant), 32'h0);
    chk("s5_async_valid", 32'(Valid), 32'h0);
    chk("s5_async_timeout", 32'(tmo), 32'h0);
    expect_evt("s5_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 0);
    req = 4'b0110;
    tick(2);
    rst = 1'b0;
    expect_evt("s5_after_rst", 4'b0010, 2'd1, 1'b1, 1'b0, 1);
    tick(1);
    req = 4'b0000;
    expect_evt("s5_idle", 4'b0000, 2'd1, 1'b0, 1'b0, 1);
    tick(2);

`ifdef MERAK_ARB_TIMEOUT_EN
    // watchdog: channel 0 held 8 cycles, then forced over to channel 1
    req = 4'b0011;
    expect_evt("s6_g0", 4'b0001, 2'd0, 1'b1, 1'b0, 1);
    expect_evt("s6_forced", 4'b0010, 2'd1, 1'b1, 1'b1, 9);
    tick(10);
    chk("s6_pulse_end", 32'(tmo), 32'h0);
    req = 4'b0000;
    expect_evt("s6_idle", 4'b0000, 2'd1, 1'b0, 1'b0, 1);
    tick(2);
`endif

    begin
      int budget;
      budget = 0;
      while (q.size() != 0 && budget < 20) begin
        tick(1);
        budget++;
      end
    end
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/merak_rr_arbiter.md
# merak_rr_arbiter

Parametrised round-robin channel arbiter for the Merak channel. It grants one of N requesting channels and holds that grant until the owner releases it. Grant selection generalises the fixed-priority channel encoder to any N and to a rotating priority. The arbiter sits between the channel request lines and the shared link datapath. Grant, index and valid outputs are registered.

## Interface
- N, 16, number of requesting channels, 2..64
- IW, $clog2(N), width of grant index; derived, not overridden
- TIMEOUT, 256, maximum cycles one grant may be held; used only with MERAK_ARB_TIMEOUT_EN; must be ≥2
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N  per-channel request; level, held by the requester until it is served
- done  input  1  release strobe from the current owner; ignored while Valid=0
- Grant  output  N  one-hot grant, registered
- Dout  output  IW  index of the granted channel, registered
- Valid  output  1  a grant is currently held, registered
- timeout  output  1  one-cycle pulse marking a forced release; present only with MERAK_ARB_TIMEOUT_EN

## Operation
- State machine has two states:
  - IDLE: Valid=0.
  - HOLD: Valid=1; Grant and Dout stay stable.
- Reset values:
  - State = IDLE, Grant = 0, Dout = 0, Valid = 0, timeout = 0.
  - Rotating pointer ptr = 0; watchdog counter = 0.
- Winner selection:
  - Search req starting at index ptr, going upward and wrapping N-1→0; the first set bit wins.
  - Implementation: masked search over req & ~((1<<ptr)-1). If that finds nothing, unmasked search over req.
- Entering HOLD:
  - In IDLE with req≠0, the next edge loads the winner into Grant/Dout, sets Valid, and enters HOLD.
  - On that same edge, ptr ← (winner+1) mod N.
- Release events in HOLD:
  - done=1, or
  - req[Dout]=0 (implicit release by the owner), or
  - forced timeout.
- On a release edge:
  - If any req other than the owner's is set, the next winner (searched from the already-updated ptr) is loaded directly. There is no idle bubble, and Valid stays 1.
  - Otherwise the arbiter returns to IDLE and Valid ← 0.
  - The owner's own req is excluded at the release edge, so no owner is re-granted back-to-back while it still asserts req.
- Requests arriving during HOLD are never lost. They are evaluated at the next release.
- ptr always advances past the last winner, so every continuously-requesting channel is served within N grants.
- Reset asserted mid-HOLD drops Grant/Valid asynchronously and clears ptr. There is no release handshake.

## Timing
- Latency from req rising (arbiter in IDLE) to Valid/Grant: 1 clock.
- Latency from a release edge to the next owner's Grant: 1 clock. It is the same edge that removes the previous Grant; the grants never overlap.
- Grant is always one-hot or zero. Dout is meaningful only while Valid=1 and holds its last value otherwise.
- done asserted in the same cycle as an implicit release counts as a single release.
- N not a power of two: ptr wraps at N, never at 2^IW.

## Configuration
- MERAK_ARB_TIMEOUT_EN defined:
  - The watchdog counter clears on each new grant and increments every HOLD cycle.
  - When count = TIMEOUT-1 and no other release is present, the next edge forces a release.
  - timeout is 1 for exactly the cycle after that edge.
  - The forced-out channel is handled exactly like a done release, so ptr fairness holds.
- Not defined: no counter, no timeout port; a grant is held indefinitely until done or implicit release.

## Structure
- Package merak_chan_pkg holds:
  - state encodings ST_IDLE=1'b0 and ST_HOLD=1'b1
  - the maximum-N constant
  - a clog2 helper function
- Sub-module priority_encoder_n (parameter N):
  - inputs Din[N-1:0]; outputs Dout[IW-1:0] and Valid
  - lowest set index wins; purely combinational
- The arbiter instantiates priority_encoder_n twice (masked and unmasked search).

## Test plan
- N=4, reset, req=4'b1010 held -> edge 1 Grant=0010, Dout=1, Valid=1; pulse done -> next edge Grant=1000, Dout=3.
- N=4, req=4'b1111 held, done every cycle after grant -> Dout sequence 0,1,2,3,0.
- N=4, owner 2 drops req[2] with no done, req=0 otherwise -> next edge Valid=0, Grant=0000.
- N=4, owner 1 done while req[1] still set and req[0]=1 -> next grant is channel 0, not 1.
- Reset mid-HOLD -> Grant, Valid, and timeout read 0 immediately, before any clock edge; first grant after reset is the lowest requesting index.
- MERAK_ARB_TIMEOUT_EN, TIMEOUT=8, N=4, req=4'b0011, no done -> Grant to 0 held 8 cycles, then forced release; timeout=1 together with Grant=0010 for one cycle.
